tdm_slot_scheduler: RTL

Frame scheduler that shares the single serial PCM link among NCH sample producers. Runs on sysclk, paced by a one-cycle bit strobe from the clock generator. Each frame carries a sync word followed by one fixed 8-bit slot per channel. Its serial output and enable feed the parallel-to-serial, framing and FSK stages.

---
 rtl/sched_pkg.sv | 21 ++
 rtl/tdm_slot_scheduler_if.sv | 26 ++
 rtl/sched_shifter.sv | 39 +++
 rtl/tdm_slot_scheduler.sv | 139 +++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and constants for the TDM slot scheduler.
// SCHED_PARITY_EN widens each slot to 9 bits (8 data + even parity).
package sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StSlot
  } sched_state_e;

  localparam logic [7:0] DefSyncWord = 8'hE4;
  localparam logic [7:0] DefIdleByte = 8'h55;
  localparam int unsigned SyncW = 8;

`ifdef SCHED_PARITY_EN
  localparam int unsigned SlotW = 9;
`else
  localparam int unsigned SlotW = 8;
`endif

endpackage

// File: rtl/tdm_slot_scheduler_if.sv
// Producer/link-side signal bundle of the TDM slot scheduler.
interface tdm_slot_scheduler_if #(
  parameter int unsigned NCH = 4
);
  logic              bit_tick;
  logic              enable;
  logic [NCH-1:0]    ch_valid;
  logic [8*NCH-1:0]  ch_data;
  logic [NCH-1:0]    ch_ack;
  logic              ser_bit;
  logic              ser_valid;
  logic              frame_start;
  logic [2:0]        slot_idx;
  logic              busy;
  logic [15:0]       underrun_cnt;

  modport master (
    output bit_tick, enable, ch_valid, ch_data,
    input  ch_ack, ser_bit, ser_valid, frame_start, slot_idx, busy, underrun_cnt
  );

  modport slave (
    input  bit_tick, enable, ch_valid, ch_data,
    output ch_ack, ser_bit, ser_valid, frame_start, slot_idx, busy, underrun_cnt
  );
endinterface

// File: rtl/sched_shifter.sv
// Loadable MSB-first shift register; with SCHED_PARITY_EN an even-parity
// bit is appended below the loaded byte.
module sched_shifter
  import sched_pkg::*;
(
  input  logic       sysclk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic       clear_i,
  input  logic [7:0] data_i,
  output logic       bit_o
);

  logic [SlotW-1:0] sr_q;
  logic [SlotW-1:0] load_val;

  always_comb begin
`ifdef SCHED_PARITY_EN
    load_val = {data_i, ^data_i};
`else
    load_val = data_i;
`endif
  end

  always_ff @(posedge sysclk) begin
    if (reset || clear_i) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= load_val;
    end else if (shift_i) begin
      sr_q <= {sr_q[SlotW-2:0], 1'b0};
    end
  end

  // The line bit is the register MSB, so it is already registered.
  assign bit_o = sr_q[SlotW-1];

endmodule

// File: rtl/tdm_slot_scheduler.sv
// TDM frame scheduler: sync word then one slot per channel on a serial link.
// Optional SCHED_PARITY_EN adds an even-parity bit to each slot.
module tdm_slot_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned NCH       = 4,
  parameter logic [7:0]  SYNC_WORD = DefSyncWord,
  parameter logic [7:0]  IDLE_BYTE = DefIdleByte
) (
  input logic sysclk,
  input logic reset,
  tdm_slot_scheduler_if.slave bus
);

  sched_state_e   state_q;
  logic [3:0]     bit_cnt_q;
  logic [2:0]     slot_idx_q;
  logic           frame_start_q;
  logic           ser_valid_q;
  logic           busy_q;
  logic [NCH-1:0] ch_ack_q;
  logic [15:0]    underrun_q;

  logic       ld_sync, ld_slot, go_idle, sh_shift, ld_valid;
  logic [2:0] ld_idx;
  logic [7:0] sh_data;
  logic [7:0] valid_pad;
  logic [63:0] data_pad;
  logic [7:0] ack_onehot;

  // Decode what the current tick does; nothing happens without a tick.
  always_comb begin
    ld_sync  = 1'b0;
    ld_slot  = 1'b0;
    go_idle  = 1'b0;
    sh_shift = 1'b0;
    ld_idx   = slot_idx_q;
    if (bus.bit_tick) begin
      unique case (state_q)
        StIdle: ld_sync = bus.enable;
        StSync: begin
          if (bit_cnt_q == 4'(SyncW - 1)) begin
            ld_slot = 1'b1;
            ld_idx  = 3'd0;
          end else begin
            sh_shift = 1'b1;
          end
        end
        StSlot: begin
          if (bit_cnt_q == 4'(SlotW - 1)) begin
            if (slot_idx_q == 3'(NCH - 1)) begin
              ld_sync = bus.enable;
              go_idle = !bus.enable;
            end else begin
              ld_slot = 1'b1;
              ld_idx  = slot_idx_q + 3'd1;
            end
          end else begin
            sh_shift = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_pad  = 8'(bus.ch_valid);
    data_pad   = 64'(bus.ch_data);
    ld_valid   = valid_pad[ld_idx];
    ack_onehot = 8'd1 << ld_idx;
    if (ld_sync) begin
      sh_data = SYNC_WORD;
    end else if (ld_valid) begin
      sh_data = data_pad[{ld_idx, 3'b000} +: 8];
    end else begin
      sh_data = IDLE_BYTE;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      slot_idx_q    <= '0;
      frame_start_q <= 1'b0;
      ser_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      ch_ack_q      <= '0;
      underrun_q    <= '0;
    end else begin
      frame_start_q <= 1'b0;
      ch_ack_q      <= '0;
      if (ld_sync) begin
        state_q       <= StSync;
        bit_cnt_q     <= '0;
        slot_idx_q    <= '0;
        frame_start_q <= 1'b1;
        ser_valid_q   <= 1'b1;
        busy_q        <= 1'b1;
      end else if (ld_slot) begin
        state_q    <= StSlot;
        bit_cnt_q  <= '0;
        slot_idx_q <= ld_idx;
        if (ld_valid) begin
          ch_ack_q <= ack_onehot[NCH-1:0];
        end else if (underrun_q != 16'hFFFF) begin
          underrun_q <= underrun_q + 16'd1;
        end
      end else if (go_idle) begin
        state_q     <= StIdle;
        bit_cnt_q   <= '0;
        slot_idx_q  <= '0;
        ser_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else if (sh_shift) begin
        bit_cnt_q <= bit_cnt_q + 4'd1;
      end
    end
  end

  sched_shifter u_shifter (
    .sysclk  (sysclk),
    .reset   (reset),
    .load_i  (ld_sync || ld_slot),
    .shift_i (sh_shift),
    .clear_i (go_idle),
    .data_i  (sh_data),
    .bit_o   (bus.ser_bit)
  );

  assign bus.ch_ack       = ch_ack_q;
  assign bus.ser_valid    = ser_valid_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.slot_idx     = slot_idx_q;
  assign bus.busy         = busy_q;
  assign bus.underrun_cnt = underrun_q;

endmodule
